// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant of one completing FU per cycle, registered broadcast.
// Define CDB_STARVE_EN to add per-requester wait counters that force priority past STARVE_LIMIT.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef PHYS_REG_IDX_SZ
`define PHYS_REG_IDX_SZ 6
`endif
`ifndef ZERO_REG
`define ZERO_REG 0
`endif

module cdb_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ROB_IDX_W    = 5,
    parameter int STARVE_LIMIT = 7
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      squash,
    input  logic [NUM_REQ-1:0]                        req_valid,
    input  logic [NUM_REQ-1:0][`PHYS_REG_IDX_SZ:0]    req_tag,
    input  logic [NUM_REQ-1:0][`XLEN-1:0]             req_data,
    input  logic [NUM_REQ-1:0][ROB_IDX_W-1:0]         req_rob_idx,
    output logic [NUM_REQ-1:0]                        req_ready,
    output logic                                      cdb_valid,
    output logic                                      cdb_wr_en,
    output logic [`PHYS_REG_IDX_SZ:0]                 cdb_tag,
    output logic [`XLEN-1:0]                          cdb_data,
    output logic [ROB_IDX_W-1:0]                      cdb_rob_idx,
    output logic [NUM_REQ-1:0]                        fu_free
);

    localparam int TAG_W = `PHYS_REG_IDX_SZ + 1;
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [TAG_W-1:0] ZERO_TAG = TAG_W'(`ZERO_REG);

    if (NUM_REQ < 2 || NUM_REQ > 8 || STARVE_LIMIT < 1) begin : g_param_check
        $error("cdb_arbiter: NUM_REQ must be 2..8 and STARVE_LIMIT >= 1");
    end

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   grant_idx;
    logic               found;
    logic [NUM_REQ-1:0] grant;

`ifdef CDB_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
    logic [NUM_REQ-1:0][CNT_W-1:0] wait_cnt;
`endif

    // Starved requesters (lowest index first) pre-empt the round-robin search.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        grant     = '0;
`ifdef CDB_STARVE_EN
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i] && wait_cnt[i] >= LIMIT) begin
                found     = 1'b1;
                grant_idx = PTR_W'(i);
            end
        end
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[(int'(ptr) + k) % NUM_REQ]) begin
                found     = 1'b1;
                grant_idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
        if (found && !squash && reset) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign req_ready = grant;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (squash) begin
            ptr <= '0;
        end else if (|grant) begin
            ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // grant is already forced to zero under squash, so the broadcast drops with it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cdb_valid   <= 1'b0;
            cdb_wr_en   <= 1'b0;
            cdb_tag     <= '0;
            cdb_data    <= '0;
            cdb_rob_idx <= '0;
            fu_free     <= '0;
        end else begin
            cdb_valid <= |grant;
            cdb_wr_en <= (|grant) && (req_tag[grant_idx] != ZERO_TAG);
            fu_free   <= grant;
            if (|grant) begin
                cdb_tag     <= req_tag[grant_idx];
                cdb_data    <= req_data[grant_idx];
                cdb_rob_idx <= req_rob_idx[grant_idx];
            end
        end
    end

`ifdef CDB_STARVE_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (squash || !req_valid[i] || grant[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] < LIMIT) begin
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed table, corner sequences and a randomized run
// against a behavioural model. Define CDB_STARVE_EN to also exercise forced priority.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef PHYS_REG_IDX_SZ
`define PHYS_REG_IDX_SZ 6
`endif
`ifndef ZERO_REG
`define ZERO_REG 0
`endif

module tb_cdb_arbiter;
    localparam int N  = 4;
    localparam int RW = 5;
    localparam int TW = `PHYS_REG_IDX_SZ + 1;
    localparam int XW = `XLEN;
`ifdef CDB_STARVE_EN
    localparam int SL = 2;
`else
    localparam int SL = 7;
`endif

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    squash;
    logic [N-1:0]            req_valid;
    logic [N-1:0][TW-1:0]    req_tag;
    logic [N-1:0][XW-1:0]    req_data;
    logic [N-1:0][RW-1:0]    req_rob_idx;
    logic [N-1:0]            req_ready;
    logic                    cdb_valid;
    logic                    cdb_wr_en;
    logic [TW-1:0]           cdb_tag;
    logic [XW-1:0]           cdb_data;
    logic [RW-1:0]           cdb_rob_idx;
    logic [N-1:0]            fu_free;

    cdb_arbiter #(.NUM_REQ(N), .ROB_IDX_W(RW), .STARVE_LIMIT(SL)) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
        .req_rob_idx(req_rob_idx), .req_ready(req_ready),
        .cdb_valid(cdb_valid), .cdb_wr_en(cdb_wr_en), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .cdb_rob_idx(cdb_rob_idx), .fu_free(fu_free)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int m_ptr;
    int m_wait [N];

    typedef struct {
        logic [N-1:0] valid;
        logic         sq;
        logic [N-1:0] exp_ready;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        for (int i = 0; i < N; i++) m_wait[i] = 0;
    endtask

    function automatic int model_pick();
        if (squash || !reset) return -1;
`ifdef CDB_STARVE_EN
        for (int i = 0; i < N; i++)
            if (req_valid[i] && m_wait[i] >= SL) return i;
`endif
        for (int k = 0; k < N; k++)
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    // Called at posedge+1 with inputs already driven; ends at the next posedge+1.
    task automatic step(input bit chk_tab, input logic [N-1:0] want, output int g);
        logic [N-1:0] mr;
        logic         e_valid, e_wr;
        logic [TW-1:0] e_tag;
        logic [XW-1:0] e_data;
        logic [RW-1:0] e_rob;
        #3;
        g  = model_pick();
        mr = (g >= 0) ? N'(1 << g) : '0;
        check("req_ready_model", 64'(req_ready), 64'(mr));
        if (chk_tab) check("req_ready_table", 64'(req_ready), 64'(want));
        e_valid = (g >= 0);
        e_wr    = (g >= 0) && (req_tag[g] != TW'(`ZERO_REG));
        e_tag   = (g >= 0) ? req_tag[g] : '0;
        e_data  = (g >= 0) ? req_data[g] : '0;
        e_rob   = (g >= 0) ? req_rob_idx[g] : '0;
        if (squash) begin
            model_reset();
        end else begin
            for (int i = 0; i < N; i++)
                m_wait[i] = (req_valid[i] && i != g) ? ((m_wait[i] + 1 > SL) ? SL : m_wait[i] + 1) : 0;
            if (g >= 0) m_ptr = (g + 1) % N;
        end
        @(posedge clock);
        #1;
        check("cdb_valid", 64'(cdb_valid), 64'(e_valid));
        check("cdb_wr_en", 64'(cdb_wr_en), 64'(e_wr));
        check("fu_free", 64'(fu_free), 64'(mr));
        if (e_valid) begin
            check("cdb_tag", 64'(cdb_tag), 64'(e_tag));
            check("cdb_data", 64'(cdb_data), 64'(e_data));
            check("cdb_rob_idx", 64'(cdb_rob_idx), 64'(e_rob));
        end
    endtask

    vec_t tab [$];
    logic [N-1:0] pend;
    int g;

    initial begin
        reset = 1'b0; squash = 1'b0; req_valid = '1;
        for (int i = 0; i < N; i++) begin
            req_tag[i]     = TW'(i + 1);
            req_data[i]    = XW'(32'h1000_0000 + i);
            req_rob_idx[i] = RW'(i + 10);
        end
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_cdb_valid", 64'(cdb_valid), 64'(0));
        check("rst_fu_free", 64'(fu_free), 64'(0));
        check("rst_cdb_data", 64'(cdb_data), 64'(0));
        check("rst_cdb_rob_idx", 64'(cdb_rob_idx), 64'(0));
        reset = 1'b1;

        // Directed table: rotation, squash, wrap-around
        tab.push_back('{4'b1111, 1'b0, 4'b0001});
        tab.push_back('{4'b1111, 1'b0, 4'b0010});
        tab.push_back('{4'b1111, 1'b0, 4'b0100});
        tab.push_back('{4'b1111, 1'b0, 4'b1000});
        tab.push_back('{4'b1111, 1'b0, 4'b0001});
        tab.push_back('{4'b0011, 1'b1, 4'b0000});
        tab.push_back('{4'b0011, 1'b0, 4'b0001});
        tab.push_back('{4'b0110, 1'b0, 4'b0010});
        tab.push_back('{4'b0110, 1'b0, 4'b0100});
        tab.push_back('{4'b0110, 1'b0, 4'b0010});
        tab.push_back('{4'b0000, 1'b0, 4'b0000});
        foreach (tab[t]) begin
            req_valid = tab[t].valid;
            squash    = tab[t].sq;
            step(1'b1, tab[t].exp_ready, g);
        end
        squash = 1'b0;

        // Single requester with fixed payload: back-to-back, no bubble
        req_valid = 4'b0100; req_tag[2] = TW'(5); req_data[2] = XW'(32'hDEAD_BEEF);
        repeat (3) begin
            step(1'b1, 4'b0100, g);
            check("solo_tag", 64'(cdb_tag), 64'(5));
            check("solo_data", 64'(cdb_data), 64'(32'hDEAD_BEEF));
        end

        // Zero-register destination: broadcast without regfile write
        req_valid = 4'b0010; req_tag[1] = TW'(`ZERO_REG);
        step(1'b1, 4'b0010, g);
        check("zero_wr_en", 64'(cdb_wr_en), 64'(0));
        check("zero_free", 64'(fu_free), 64'(4'b0010));
        req_tag[1] = TW'(2);

        // Asynchronous reset mid-broadcast
        req_valid = 4'b0001;
        step(1'b1, 4'b0001, g);
        check("pre_rst_valid", 64'(cdb_valid), 64'(1));
        #2 reset = 1'b0;
        #1;
        check("async_cdb_valid", 64'(cdb_valid), 64'(0));
        check("async_wr_en", 64'(cdb_wr_en), 64'(0));
        check("async_tag", 64'(cdb_tag), 64'(0));
        check("async_data", 64'(cdb_data), 64'(0));
        check("async_fu_free", 64'(fu_free), 64'(0));
        check("async_ready", 64'(req_ready), 64'(0));
        model_reset();
        reset = 1'b1; req_valid = 4'b0110;
        step(1'b1, 4'b0010, g);

`ifdef CDB_STARVE_EN
        // FU3 loses twice, then wins over the round-robin choice
        squash = 1'b1; req_valid = '0;
        step(1'b1, 4'b0000, g);
        squash = 1'b0;
        req_valid = 4'b1001; step(1'b1, 4'b0001, g);
        req_valid = 4'b1010; step(1'b1, 4'b0010, g);
        req_valid = 4'b1101; step(1'b1, 4'b1000, g);
`endif

        // Randomized traffic; requesters hold until granted
        pend = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i]        = 1'b1;
                    req_tag[i]     = ($urandom_range(0, 7) == 0) ? TW'(`ZERO_REG) : TW'($urandom);
                    req_data[i]    = XW'($urandom);
                    req_rob_idx[i] = RW'($urandom);
                end
            end
            req_valid = pend;
            squash    = ($urandom_range(0, 19) == 0);
            step(1'b0, '0, g);
            if (g >= 0) pend[g] = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of completing functional units sharing the CDB (range 2..8).
REQ-002 Parameter ROB_IDX_W, default 5: ROB index width.
REQ-003 Parameter STARVE_LIMIT, default 7: wait-cycle threshold for the forced-priority feature (REQ-024).
REQ-004 The ports SHALL be as follows; one clock; reset is asynchronous and active-low:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- squash  in  1  pipeline flush, synchronous
- req_valid  in  NUM_REQ  per-FU completion request
- req_tag  in  NUM_REQ x (`PHYS_REG_IDX_SZ+1)  destination physical register per FU
- req_data  in  NUM_REQ x `XLEN  result per FU
- req_rob_idx  in  NUM_REQ x ROB_IDX_W  ROB entry per FU
- req_ready  out  NUM_REQ  one-hot grant; the FU's request is consumed this cycle
- cdb_valid  out  1  CDB broadcast valid
- cdb_wr_en  out  1  regfile write enable (cdb_valid and tag != `ZERO_REG)
- cdb_tag  out  `PHYS_REG_IDX_SZ+1  broadcast tag
- cdb_data  out  `XLEN  broadcast data
- cdb_rob_idx  out  ROB_IDX_W  ROB entry to mark complete
- fu_free  out  NUM_REQ  one-hot; FU whose result is on the CDB is freed

Function
REQ-005 At most one request SHALL be granted per cycle; req_ready is combinational from req_valid, the priority pointer, squash and starvation state.
REQ-006 A request is transferred when req_valid[i] and req_ready[i] are both high; a requester SHALL hold valid, tag, data and rob_idx stable until granted.
REQ-007 Arbitration SHALL be round-robin: search starts at index ptr and wraps modulo NUM_REQ; the first valid index wins.
REQ-008 After a grant to index g, ptr SHALL become (g+1) mod NUM_REQ; with no grant, ptr SHALL hold.
REQ-009 Latency SHALL be one cycle: a request granted in cycle t appears on cdb_* and fu_free in cycle t+1 for exactly one cycle.
REQ-010 With no grant in cycle t, cdb_valid, cdb_wr_en and fu_free SHALL be 0 in t+1; cdb_tag, cdb_data and cdb_rob_idx SHALL be don't-care.
REQ-011 cdb_wr_en SHALL be 0 when the granted tag equals `ZERO_REG; cdb_valid and fu_free SHALL still assert.
REQ-012 fu_free SHALL be one-hot of the index granted in the previous cycle, or zero.
REQ-013 When squash is high in cycle t: req_ready SHALL be all-zero, and cdb_valid, cdb_wr_en and fu_free SHALL be 0 in t+1. This holds even if the cycle-t cdb_* outputs were valid.
REQ-014 When squash is high, ptr SHALL reset to 0 and all starvation counters SHALL clear.
REQ-015 All-requesters-valid SHALL yield grants in strict rotation: ptr, ptr+1, ... wrapping.
REQ-016 A single valid requester SHALL be granted every cycle, back-to-back, with no bubble.

Reset
REQ-017 While reset is low, all registers SHALL take reset values asynchronously.
REQ-018 Reset values: cdb_valid=0, cdb_wr_en=0, cdb_tag=0, cdb_data=0, cdb_rob_idx=0, fu_free=0, ptr=0, starvation counters=0.
REQ-019 req_ready SHALL be all-zero while reset is low.
REQ-020 On the first rising edge after reset deasserts, normal arbitration SHALL resume.
REQ-021 Reset asserted mid-broadcast SHALL drop cdb_valid immediately; the in-flight result is lost; requesters re-present their requests after reset.

Configuration
REQ-022 Macro CDB_STARVE_EN SHALL select the starvation-prevention feature.
REQ-023 Without CDB_STARVE_EN, the block SHALL be pure round-robin per REQ-007/008 and SHALL contain no counters.
REQ-024 With CDB_STARVE_EN, each requester SHALL have a saturating wait counter. The counter increments while valid and not granted, and clears on grant or when valid is low. A requester whose counter is >= STARVE_LIMIT SHALL win over round-robin order. If several qualify, the lowest index wins. ptr still updates per REQ-008.

Verification
REQ-025 Reset, then req_valid=4'b1111 for 4 cycles -> req_ready 0001,0010,0100,1000; cdb_rob_idx follows the same order one cycle later.
REQ-026 Only FU2 valid with tag=5, data=32'hDEAD_BEEF for 3 cycles -> cdb_valid high for 3 consecutive cycles starting 1 cycle later; cdb_tag=5; fu_free=4'b0100 each cycle.
REQ-027 FU1 valid with tag=`ZERO_REG -> next cycle cdb_valid=1, cdb_wr_en=0, fu_free=4'b0010.
REQ-028 Squash in the same cycle as req_valid=4'b0011 -> req_ready=0; next cycle cdb_valid=0 and ptr=0; following grant goes to FU0.
REQ-029 Reset asserted asynchronously mid-cycle while cdb_valid=1 -> cdb_valid falls before the next clock edge; all outputs are 0.
REQ-030 With CDB_STARVE_EN and STARVE_LIMIT=2: hold FU3 valid, then pulse FU0-FU2 valid so FU3 loses twice -> FU3 granted on the next cycle regardless of ptr.
